// File: rtl/sw_reader_if.sv
// Register read port of the switch reader: single-cycle strobe in, registered ack/data out,
// plus the level interrupt raised by pending edge flags.
interface sw_reader_if;
  logic        rd_req;
  logic [1:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_ack;
  logic        irq;

  modport master (output rd_req, rd_addr, input rd_data, rd_ack, irq);
  modport slave  (input rd_req, rd_addr, output rd_data, rd_ack, irq);
endinterface

// File: rtl/sw_reader.sv
// Debounced board-switch reader: per-switch synchronizer + debounce counter, sticky
// rise/fall flags with read-to-clear, 16-bit change counter, and a 1-cycle read port.

module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic stable,
  output logic fire
);
  localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

  logic [1:0]  sync_q;
  logic [15:0] cnt;
  logic        sync;

  assign sync = sync_q[1];
  // The new level is accepted on the cycle the counter has already seen DEBOUNCE_CYCLES-1 mismatches.
  assign fire = (sync != stable) && (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], sw};
      if (sync == stable) begin
        cnt <= '0;
      end else if (fire) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end
endmodule

module sw_reader #(
  parameter int N_SW            = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_SW-1:0] sw,
  sw_reader_if.slave      bus
);
  logic [N_SW-1:0] stable, fire;
  logic [N_SW-1:0] rise_q, fall_q, rise_d, fall_d;
  logic [15:0]     chg_cnt, n_fire;
  logic [31:0]     rd_mux;
  logic            rd_rise, rd_fall;
  logic [1:0]      vld_pipe;

  for (genvar i = 0; i < N_SW; i++) begin : g_lane
    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .reset  (reset),
      .sw     (sw[i]),
      .stable (stable[i]),
      .fire   (fire[i])
    );
  end

  always_comb begin
    n_fire = '0;
    for (int i = 0; i < N_SW; i++) n_fire = n_fire + 16'(fire[i]);
  end

  assign rd_rise = bus.rd_req && (bus.rd_addr == 2'd1);
  assign rd_fall = bus.rd_req && (bus.rd_addr == 2'd2);

  // Clear happens at the same edge that returns the old value; a simultaneous event survives.
  assign rise_d = (rd_rise ? '0 : rise_q) | (fire & ~stable);
  assign fall_d = (rd_fall ? '0 : fall_q) | (fire &  stable);

  always_comb begin
    rd_mux = '0;
    case (bus.rd_addr)
      2'd0:    rd_mux = 32'(stable);
      2'd1:    rd_mux = 32'(rise_q);
      2'd2:    rd_mux = 32'(fall_q);
      default: rd_mux = 32'(chg_cnt);
    endcase
  end

  assign vld_pipe[0] = bus.rd_req;
  assign bus.rd_ack  = vld_pipe[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      rise_q      <= '0;
      fall_q      <= '0;
      chg_cnt     <= '0;
      bus.irq     <= 1'b0;
      vld_pipe[1] <= 1'b0;
      bus.rd_data <= '0;
    end else begin
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      chg_cnt     <= chg_cnt + n_fire;
      bus.irq     <= |{rise_d, fall_d};
      vld_pipe[1] <= vld_pipe[0];
      bus.rd_data <= vld_pipe[0] ? rd_mux : '0;
    end
  end
endmodule

// File: tb/tb_sw_reader.sv
// Bench for sw_reader: window-based reference model feeding a read scoreboard, directed
// scenarios for latency, glitches, simultaneous edges, read/event race, reset, and wrap.
module tb_sw_reader;
  localparam int N = 4;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  sw;
  logic [15:0]   sw_w;

  always #5 clk = ~clk;

  sw_reader_if bus();
  sw_reader_if bus_w();

  sw_reader #(.N_SW(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(rst), .sw(sw), .bus(bus)
  );

  sw_reader #(.N_SW(16), .DEBOUNCE_CYCLES(1)) u_wrap (
    .clk(clk), .reset(rst), .sw(sw_w), .bus(bus_w)
  );

  int n_chk = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  // reference model state
  logic [N-1:0] m_stable, m_rise, m_fall;
  logic [15:0]  m_chg;
  logic         m_ack, m_irq;
  logic [N-1:0] pipe[$];
  logic [N-1:0] win[$];
  logic [31:0]  expq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // A switch accepts a new level once its last D synchronized samples all disagree with it.
  always @(posedge clk) begin : model
    logic [N-1:0] s, ev;
    bit diff;
    if (rst) begin
      m_stable = '0; m_rise = '0; m_fall = '0; m_chg = '0; m_ack = 1'b0;
      pipe.delete(); pipe.push_back('0); pipe.push_back('0);
      win.delete();
    end else begin
      if (bus.rd_req) begin
        case (bus.rd_addr)
          2'd0:    expq.push_back(32'(m_stable));
          2'd1:    expq.push_back(32'(m_rise));
          2'd2:    expq.push_back(32'(m_fall));
          default: expq.push_back(32'(m_chg));
        endcase
      end
      s = pipe.pop_front();
      pipe.push_back(sw);
      win.push_back(s);
      if (win.size() > D) void'(win.pop_front());
      ev = '0;
      if (win.size() == D) begin
        for (int i = 0; i < N; i++) begin
          diff = 1'b1;
          for (int k = 0; k < D; k++) if (win[k][i] == m_stable[i]) diff = 1'b0;
          ev[i] = diff;
        end
      end
      m_rise   = ((bus.rd_req && bus.rd_addr == 2'd1) ? '0 : m_rise) | (ev & ~m_stable);
      m_fall   = ((bus.rd_req && bus.rd_addr == 2'd2) ? '0 : m_fall) | (ev &  m_stable);
      m_stable = m_stable ^ ev;
      m_chg    = m_chg + 16'($countones(ev));
      m_ack    = bus.rd_req;
    end
    m_irq = |{m_rise, m_fall};
  end

  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (mon_en) begin
      chk("rd_ack", 32'(bus.rd_ack), 32'(m_ack));
      if (bus.rd_ack || m_ack) begin
        if (expq.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL rd_data: ack with no pending request at %0t", $time);
        end else begin
          e = expq.pop_front();
          chk("rd_data", bus.rd_data, e);
        end
      end else begin
        chk("rd_data_idle", bus.rd_data, 32'h0);
      end
      chk("irq", 32'(bus.irq), 32'(m_irq));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp, input string name);
    bus.rd_req = 1'b1; bus.rd_addr = a;
    @(negedge clk);
    bus.rd_req = 1'b0;
    chk({name, "_ack"}, 32'(bus.rd_ack), 32'h1);
    chk(name, bus.rd_data, exp);
  endtask

  task automatic irq_lat(input string name);
    int lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (bus.irq) lat = k;
    end
    chk(name, 32'(lat), 32'd6);
  endtask

  task automatic rd_w(input logic [31:0] exp, input string name);
    bus_w.rd_req = 1'b1; bus_w.rd_addr = 2'd3;
    @(negedge clk);
    bus_w.rd_req = 1'b0;
    chk(name, bus_w.rd_data, exp);
  endtask

  initial begin
    rst = 1'b1; sw = '0; sw_w = '0;
    bus.rd_req = 1'b1; bus.rd_addr = 2'd1;
    bus_w.rd_req = 1'b0; bus_w.rd_addr = 2'd0;
    @(negedge clk);
    mon_en = 1'b1;
    tick(2);
    chk("rst_ack", 32'(bus.rd_ack), 32'h0);
    chk("rst_data", bus.rd_data, 32'h0);
    chk("rst_irq", 32'(bus.irq), 32'h0);
    chk("rst_wrap_data", bus_w.rd_data, 32'h0);
    rst = 1'b0; bus.rd_req = 1'b0;

    // clean rise on sw[0]
    tick(3);
    sw[0] = 1'b1;
    irq_lat("lat_sw0");
    rd_chk(2'd1, 32'h1, "rise_sw0");
    rd_chk(2'd1, 32'h0, "rise_clr");
    chk("irq_clr", 32'(bus.irq), 32'h0);

    // short glitches on sw[1] never reach stable
    for (int r = 0; r < 5; r++) begin
      sw[1] = 1'b1; tick(3);
      sw[1] = 1'b0; tick(3);
    end
    tick(8);
    rd_chk(2'd0, 32'h1, "stable_glitch");
    rd_chk(2'd3, 32'h1, "chg_glitch");
    chk("irq_glitch", 32'(bus.irq), 32'h0);

    // simultaneous edges
    sw[3:2] = 2'b11;
    tick(10);
    rd_chk(2'd0, 32'hD, "stable_pair");
    rd_chk(2'd1, 32'hC, "rise_pair");
    rd_chk(2'd3, 32'h3, "chg_pair");

    // read of fall in the exact cycle a new fall event fires
    sw[1] = 1'b1; tick(8);
    rd_chk(2'd1, 32'h2, "rise_sw1");
    sw[1] = 1'b0; tick(8);
    sw[0] = 1'b0; tick(5);
    rd_chk(2'd2, 32'h2, "fall_race");
    chk("irq_race", 32'(bus.irq), 32'h1);
    rd_chk(2'd2, 32'h1, "fall_after");

    // reset mid-debounce, with a flag pending and a request dropped
    sw[1] = 1'b1; tick(8);
    sw[0] = 1'b1; tick(5);
    rst = 1'b1; bus.rd_req = 1'b1; bus.rd_addr = 2'd0;
    @(negedge clk);
    rst = 1'b0; bus.rd_req = 1'b0;
    chk("rst2_ack", 32'(bus.rd_ack), 32'h0);
    chk("rst2_data", bus.rd_data, 32'h0);
    chk("rst2_irq", 32'(bus.irq), 32'h0);
    irq_lat("lat_after_rst");
    rd_chk(2'd1, 32'hF, "rise_after_rst");
    rd_chk(2'd3, 32'h4, "chg_after_rst");
    rd_chk(2'd0, 32'hF, "stable_after_rst");

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(5) == 0) begin
        int b = $urandom_range(N - 1);
        sw[b] = ~sw[b];
      end
      bus.rd_req  = ($urandom_range(2) == 0);
      bus.rd_addr = 2'($urandom_range(3));
      rst         = ($urandom_range(499) == 0);
      @(negedge clk);
    end
    rst = 1'b0; bus.rd_req = 1'b0;
    tick(2);

    // change counter wrap on a 16-switch, single-cycle debounce instance
    rd_w(32'h0, "wrap_start");
    for (int k = 0; k < 4095; k++) begin
      sw_w = ~sw_w;
      @(negedge clk);
    end
    tick(4);
    rd_w(32'hFFF0, "wrap_fff0");
    sw_w[14:0] = ~sw_w[14:0];
    tick(4);
    rd_w(32'hFFFF, "wrap_ffff");
    sw_w[15] = ~sw_w[15];
    tick(4);
    rd_w(32'h0, "wrap_zero");

    tick(2);
    chk("scoreboard_drained", 32'(expq.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/sw_reader.md
SW_READER -- requirements
Module: sw_reader

Interface
REQ-001 Parameter N_SW, default 4: number of board switch inputs, range 1..16.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles required to accept a new level; range 1..65535; 1 ms at 50 MHz.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sw  input  N_SW  raw asynchronous board switch levels.
REQ-006 rd_req  input  1  read strobe from core, one request per cycle it is high.
REQ-007 rd_addr  input  2  register select, sampled with rd_req.
REQ-008 rd_data  output  32  read data, valid only while rd_ack=1.
REQ-009 rd_ack  output  1  read completion, one pulse per accepted rd_req.
REQ-010 irq  output  1  high while any sticky edge flag is set.

Function
REQ-011 Each sw bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Per switch: 16-bit counter cnt and debounced level stable.
- sync == stable: cnt cleared to 0.
- sync != stable and cnt < DEBOUNCE_CYCLES-1: cnt increments.
- sync != stable and cnt == DEBOUNCE_CYCLES-1: stable <= sync, cnt <= 0, edge event fires this cycle.
REQ-013 Latency from a clean sw change to stable update SHALL be exactly 2 + DEBOUNCE_CYCLES cycles; any glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL never change stable.
REQ-014 A 0->1 stable update SHALL set rise[i]; a 1->0 update SHALL set fall[i]; flags are sticky.
REQ-015 chg_cnt, 16-bit, SHALL increment once per cycle per number of switches updating that cycle (simultaneous updates add their count); wraps 0xFFFF -> 0x0000.
REQ-016 Register map, unused upper bits read 0:
- 0: stable[N_SW-1:0]
- 1: rise[N_SW-1:0], read-to-clear
- 2: fall[N_SW-1:0], read-to-clear
- 3: chg_cnt[15:0]
REQ-017 rd_ack SHALL assert exactly one cycle after each cycle with rd_req=1; rd_data carries the register value as of the rd_req cycle. Back-to-back requests SHALL give back-to-back acks. With rd_req=0, rd_ack=0 and rd_data=0.
REQ-018 Read-to-clear SHALL clear the flags in the cycle following the rd_req cycle, together with rd_ack. A new edge event for bit i in that same cycle leaves flag[i] set. Other bits clear.
REQ-019 irq = OR of all rise and fall bits, registered in step with the flags.
REQ-020 Reads SHALL have no effect on stable, cnt, or chg_cnt.

Reset
REQ-021 While reset=1 on a clock edge, the following SHALL be 0: synchronizer flops, stable, every cnt, rise, fall, chg_cnt, rd_ack, rd_data, and irq.
REQ-022 rd_req during reset SHALL be dropped, producing no ack.
REQ-023 After reset, a switch already high SHALL be treated as a normal 0->1 transition. It is accepted after 2+DEBOUNCE_CYCLES cycles and sets rise[i].
REQ-024 Reset asserted mid-debounce SHALL discard the partial count.

Verification (DEBOUNCE_CYCLES=4, N_SW=4)
REQ-025 Hold sw=0000, then raise sw[0] from reset release:
- rd_ack stays 0.
- stable[0] becomes 1 exactly 6 cycles after the change.
- irq rises in the same cycle.
- Read addr 1 -> rd_data=0x1 with ack.
- Read addr 1 again -> 0x0, and irq=0.
REQ-026 Toggle sw[1] high for 3 cycles then low, repeated 5 times -> stable stays 0000, chg_cnt=0, irq stays 0.
REQ-027 Raise sw[2] and sw[3] in the same cycle -> both stable bits update in the same cycle, chg_cnt increments by 2, and addr 1 reads 0xC.
REQ-028 Issue the addr 2 read in the exact cycle a new falling event on sw[0] fires, with fall=0x2 already pending. The read returns 0x2; afterwards fall=0x1 and irq=1.
REQ-029 Preload chg_cnt to 0xFFFF through transitions, then cause one more transition -> addr 3 reads 0x0000.
REQ-030 Assert reset for 1 cycle while sw[0] is 3 cycles into its debounce. All outputs read 0 the next cycle. stable[0] updates 6 cycles after reset deasserts.
